// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity frame generator.
// Holds the FSM state type, parity mode constants and the word parity helper.
package parity_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } par_state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // data is the XOR-reduced word; mode flips even to odd parity
  function automatic logic word_parity(
    input logic data,
    input logic mode
  );
    return data ^ mode;
  endfunction

endpackage

// File: rtl/parity_frame_gen_tree.sv
// XOR reduction of a DATA_W-bit word, purely combinational.
// Ports: data (DATA_W in), par (1 out, 1 when an odd number of bits set).
module parity_tree #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);

  assign par = ^data;

endmodule

// File: rtl/parity_frame_gen.sv
// Streaming parity generator: per-word parity plus running frame parity.
// Ports: clk, rst_n, odd_mode, in_* stream, out_* stream, frame_cnt.
// Optional PARITY_CHECK_EN adds chk_par input and err_sticky output.
module parity_frame_gen
  import parity_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wpar,
  output logic              out_last,
  output logic              out_fpar,
  output logic              out_trunc,
  output logic [CNT_W-1:0]  frame_cnt
`ifdef PARITY_CHECK_EN
  ,
  input  logic              chk_par,
  output logic              err_sticky
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  par_state_t       state, state_n;
  logic             mode, mode_eff;
  logic             acc, acc_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             tree_par;
  logic             wpar;
  logic             last_n, trunc_n;
  logic             accept;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data (in_data),
    .par  (tree_par)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // mode is only sampled on the first word of a frame
  assign mode_eff = (state == IDLE) ? odd_mode : mode;
  assign wpar     = word_parity(tree_par, mode_eff);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    last_n  = 1'b0;
    trunc_n = 1'b0;
    case (state)
      IDLE: begin
        acc_n   = tree_par;
        cnt_n   = LEN_W'(1);
        last_n  = in_last;
        state_n = in_last ? IDLE : FRAME;
      end
      default: begin
        acc_n   = acc ^ tree_par;
        cnt_n   = cnt + LEN_W'(1);
        trunc_n = !in_last && (cnt_n == LEN_W'(MAX_LEN));
        last_n  = in_last || trunc_n;
        state_n = last_n ? IDLE : FRAME;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= EVEN;
      acc   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      state <= state_n;
      mode  <= mode_eff;
      acc   <= acc_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_wpar  <= 1'b0;
      out_last  <= 1'b0;
      out_fpar  <= 1'b0;
      out_trunc <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_wpar  <= wpar;
      out_last  <= last_n;
      out_fpar  <= word_parity(acc_n, mode_eff);
      out_trunc <= trunc_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (out_valid && out_ready && out_last) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (accept && (chk_par != wpar)) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_gen.sv
// Directed bench for parity_frame_gen with hand-computed expectations.
// Define PARITY_CHECK_EN to also exercise the sticky parity checker.
module tb_parity_frame_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       odd_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_wpar;
  logic       out_last;
  logic       out_fpar;
  logic       out_trunc;
  logic [7:0] frame_cnt;
`ifdef PARITY_CHECK_EN
  logic       chk_par = 1'b0;
  logic       err_sticky;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_frame_gen #(
    .DATA_W (8),
    .MAX_LEN(16),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .odd_mode  (odd_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_wpar  (out_wpar),
    .out_last  (out_last),
    .out_fpar  (out_fpar),
    .out_trunc (out_trunc),
    .frame_cnt (frame_cnt)
`ifdef PARITY_CHECK_EN
    ,
    .chk_par   (chk_par),
    .err_sticky(err_sticky)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one word with out_ready high; outputs checked just after the edge
  task automatic beat(input string tag, input logic [7:0] d,
                      input logic l, input logic m,
                      input logic ewpar, input logic elast,
                      input logic efpar, input logic etrunc);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    odd_mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".wpar"}, 32'(out_wpar), 32'(ewpar));
    check({tag, ".last"}, 32'(out_last), 32'(elast));
    if (elast) begin
      check({tag, ".fpar"}, 32'(out_fpar), 32'(efpar));
      check({tag, ".trunc"}, 32'(out_trunc), 32'(etrunc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data", 32'(out_data), 32'd0);
    check("rst.cnt", 32'(frame_cnt), 32'd0);
    check("rst.last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.ready", 32'(in_ready), 32'd1);

    // even frame 01,03,07
    beat("t1w0", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    beat("t1w1", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("t1w2", 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("t1.cnt", 32'(frame_cnt), 32'd1);
    check("t1.drain", 32'(out_valid), 32'd0);

    // odd frame, mode toggled mid-frame must be ignored
    beat("t2w0", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    beat("t2w1", 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    beat("t2w2", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("t2.cnt", 32'(frame_cnt), 32'd2);

    // 20 words of FF without last: forced end on the 16th
    for (int i = 1; i <= 20; i++) begin
      beat($sformatf("t3w%0d", i), 8'hFF, 1'b0, 1'b0, 1'b0,
           (i == 16), 1'b0, 1'b1);
    end
    // close the second frame: acc 0^1 -> fpar 1, normal end
    beat("t3close", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("t3.cnt", 32'(frame_cnt), 32'd4);

    // backpressure
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0F;
    in_last   = 1'b0;
    @(posedge clk);
    #1;
    check("t4.acc.valid", 32'(out_valid), 32'd1);
    check("t4.acc.data", 32'(out_data), 32'h0F);
    in_data = 8'h10;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4.stall%0d.ready", i), 32'(in_ready), 32'd0);
      check($sformatf("t4.stall%0d.data", i), 32'(out_data), 32'h0F);
      check($sformatf("t4.stall%0d.wpar", i), 32'(out_wpar), 32'd0);
      tick();
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("t4.release.ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t4.b.data", 32'(out_data), 32'h10);
    check("t4.b.wpar", 32'(out_wpar), 32'd1);
    check("t4.b.last", 32'(out_last), 32'd1);
    check("t4.b.fpar", 32'(out_fpar), 32'd1);
    tick();
    check("t4.cnt", 32'(frame_cnt), 32'd5);
    check("t4.drain", 32'(out_valid), 32'd0);

    // async reset mid-frame
    beat("t5w0", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.rst.valid", 32'(out_valid), 32'd0);
    check("t5.rst.cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat("t5new", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("t5.cnt", 32'(frame_cnt), 32'd1);

`ifdef PARITY_CHECK_EN
    @(negedge clk);
    chk_par = 1'b1;
    beat("t6ok", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6.noerr", 32'(err_sticky), 32'd0);
    @(negedge clk);
    chk_par = 1'b0;
    beat("t6bad", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6.err", 32'(err_sticky), 32'd1);
    tick();
    tick();
    check("t6.sticky", 32'(err_sticky), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6.clr", 32'(err_sticky), 32'd0);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
